// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode stage with 2-entry skid buffering, flush and decode counter.
// Define ILLEGAL_OP_TRAP_EN to drop words with op > MAX_OP and pulse illegal instead.
module instr_decode_stage #(
  parameter int OP_W   = 5,
  parameter int MODE_W = 2,
  parameter int REG_W  = 5,
  parameter int LIT_W  = 32,
  parameter logic [OP_W-1:0] BR_LO  = 5'h10,
  parameter logic [OP_W-1:0] BR_HI  = 5'h12,
  parameter logic [OP_W-1:0] ST_OP  = 5'h02,
  parameter logic [OP_W-1:0] MAX_OP = 5'h12,
  parameter int CNT_W  = 16,
  localparam int INSTR_W = OP_W + MODE_W + 2 * REG_W + LIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    op,
  output logic [MODE_W-1:0]  mode,
  output logic [REG_W-1:0]   src,
  output logic [REG_W-1:0]   dst,
  output logic [LIT_W-1:0]   litsrc,
  output logic               branch,
  output logic               store,
  output logic [CNT_W-1:0]   dec_count,
  output logic               illegal
);
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic               out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] out_q, out_d, skid_q, skid_d, nxt;
  logic               branch_q, branch_d, store_q, store_d, ill_q, ill_d;
  logic [CNT_W-1:0]   dec_q, dec_d;
  logic               accept, bad, take, hs, load, ld_new;
  logic [OP_W-1:0]    in_op, nxt_op;
  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign {op, mode, src, dst, litsrc} = out_q;
  assign branch    = branch_q;
  assign store     = store_q;
  assign dec_count = dec_q;
  assign illegal   = ill_q;
  // The skid entry, when present, always has priority over the input when the output reg frees up.
  always_comb begin
    accept       = in_valid && in_ready;
    in_op        = in_instr[INSTR_W-1 -: OP_W];
    bad          = TRAP && (in_op > MAX_OP);
    take         = accept && !bad;
    hs           = out_valid_q && out_ready;
    load         = !out_valid_q || out_ready;
    nxt          = skid_valid_q ? skid_q : in_instr;
    nxt_op       = nxt[INSTR_W-1 -: OP_W];
    ld_new       = load && (skid_valid_q || take);
    out_valid_d  = !flush && (load ? (skid_valid_q || take) : 1'b1);
    skid_valid_d = !flush && !load && (skid_valid_q || take);
    skid_d       = (!load && take) ? in_instr : skid_q;
    out_d        = ld_new ? nxt : out_q;
    branch_d     = ld_new ? (nxt_op >= BR_LO && nxt_op <= BR_HI) : branch_q;
    store_d      = ld_new ? (nxt_op == ST_OP) : store_q;
    dec_d        = dec_q + CNT_W'(hs);
    ill_d        = accept && bad && !flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
      branch_q     <= 1'b0;
      store_q      <= 1'b0;
      dec_q        <= '0;
      ill_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      branch_q     <= branch_d;
      store_q      <= store_d;
      dec_q        <= dec_d;
      ill_q        <= ill_d;
    end
  end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: random traffic against a queue-based model plus directed literal checks.
module tb_instr_decode_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [48:0] in_instr = '0;
  logic        in_ready, out_valid, branch, store, illegal;
  logic [4:0]  op, src, dst;
  logic [1:0]  mode;
  logic [31:0] litsrc;
  logic [15:0] dec_count;
  int pass_cnt = 0, tot_cnt = 0;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .op(op), .mode(mode),
    .src(src), .dst(dst), .litsrc(litsrc), .branch(branch), .store(store),
    .dec_count(dec_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
  endtask

  // Model: the stage holds an ordered list of at most two words.
  logic [48:0] q[$];
  logic [15:0] m_dec = '0;
  logic        m_ill = 1'b0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_dec = '0;
      m_ill = 1'b0;
    end else begin
      automatic bit hs  = (q.size() > 0) && out_ready;
      automatic bit acc = in_valid && (q.size() < 2);
      automatic bit bad = TRAP && (in_instr[48:44] > 5'h12);
      if (hs) m_dec = m_dec + 16'd1;
      m_ill = acc && bad && !flush;
      if (flush) q.delete();
      else begin
        if (hs) void'(q.pop_front());
        if (acc && !bad) q.push_back(in_instr);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("dec_count", 64'(dec_count), 64'(m_dec));
      chk("illegal", 64'(illegal), 64'(m_ill));
      if (q.size() > 0) begin
        chk("op", 64'(op), 64'(q[0][48:44]));
        chk("mode", 64'(mode), 64'(q[0][43:42]));
        chk("src", 64'(src), 64'(q[0][41:37]));
        chk("dst", 64'(dst), 64'(q[0][36:32]));
        chk("litsrc", 64'(litsrc), 64'(q[0][31:0]));
        chk("branch", 64'(branch), 64'(q[0][48:44] >= 5'h10 && q[0][48:44] <= 5'h12));
        chk("store", 64'(store), 64'(q[0][48:44] == 5'h02));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    logic [4:0]  sp[6] = '{5'h02, 5'h10, 5'h11, 5'h12, 5'h13, 5'h1F};
    r         = {$urandom, $urandom};
    in_instr  = r[48:0];
    if ($urandom % 3 == 0) in_instr[48:44] = sp[$urandom % 6];
    in_valid  = ($urandom % 4) != 0;
    out_ready = ($urandom % 3) != 0;
    flush     = ($urandom % 20) == 0;
  endtask

  initial begin
    logic [15:0] d0;
    logic [4:0]  ops[4] = '{5'h02, 5'h10, 5'h12, 5'h13};
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_dec", 64'(dec_count), 64'd0);
    rst_n = 1'b1;
    step();
    // Field slicing, one-edge latency.
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 49'h1_0A5A_1234_5678;
    step();
    in_valid = 1'b0;
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_op", 64'(op), 64'h10);
    chk("t3_mode", 64'(mode), 64'h2);
    chk("t3_src", 64'(src), 64'h12);
    chk("t3_dst", 64'(dst), 64'h1A);
    chk("t3_lit", 64'(litsrc), 64'h1234_5678);
    chk("t3_branch", 64'(branch), 64'd1);
    chk("t3_store", 64'(store), 64'd0);
    step();
    // Back-to-back at full throughput.
    d0 = dec_count;
    for (int i = 0; i < 4; i++) begin
      in_instr = {ops[i], 44'(i + 1)};
      in_valid = 1'b1;
      step();
      if (i < 3 || !TRAP) begin
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_branch", 64'(branch), 64'(i == 1 || i == 2));
        chk("t2_store", 64'(store), 64'(i == 0));
      end else begin
        chk("t2_trap_valid", 64'(out_valid), 64'd0);
        chk("t2_trap_ill", 64'(illegal), 64'd1);
      end
    end
    in_valid = 1'b0;
    step();
    chk("t2_count", 64'(dec_count - d0), TRAP ? 64'd3 : 64'd4);
    // Backpressure: two words taken, third held off, order kept.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 49'd1;
    step();
    chk("t4_rdy1", 64'(in_ready), 64'd1);
    in_instr = 49'd2;
    step();
    chk("t4_rdy2", 64'(in_ready), 64'd0);
    in_instr = 49'd3;
    step();
    chk("t4_rdy3", 64'(in_ready), 64'd0);
    chk("t4_hold", 64'(litsrc), 64'd1);
    out_ready = 1'b1;
    step();
    chk("t4_w2", 64'(litsrc), 64'd2);
    step();
    chk("t4_w3", 64'(litsrc), 64'd3);
    in_valid = 1'b0;
    step();
    // Flush with output valid and skid full.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 49'd7;
    step();
    in_instr = 49'd8;
    step();
    chk("t5_full", 64'(in_ready), 64'd0);
    d0 = dec_count;
    flush = 1'b1; in_instr = 49'd9;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_rdy", 64'(in_ready), 64'd1);
    chk("t5_count", 64'(dec_count), 64'(d0));
    // Opcode above the legal range.
    out_ready = 1'b1; in_valid = 1'b1; in_instr = {5'h1F, 44'h5};
    step();
    in_valid = 1'b0;
    chk("t6_valid", 64'(out_valid), TRAP ? 64'd0 : 64'd1);
    chk("t6_ill", 64'(illegal), TRAP ? 64'd1 : 64'd0);
    step();
    chk("t6_ill_end", 64'(illegal), 64'd0);
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    // Asynchronous reset in the middle of traffic.
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; in_instr = {5'h04, 44'hABC};
    step();
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_rdy", 64'(in_ready), 64'd1);
    chk("t1_dec", 64'(dec_count), 64'd0);
    chk("t1_op", 64'(op), 64'd0);
    chk("t1_lit", 64'(litsrc), 64'd0);
    chk("t1_ill", 64'(illegal), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      rand_inputs();
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
